// File: rtl/mc_control_unit_pkg.sv
// Shared constants and types for the TSC multi-cycle control unit:
// opcodes, funcs, ALU function codes, state encoding, select encodings.
package mc_control_unit_pkg;

  localparam int unsigned OPC_W      = 4;
  localparam int unsigned FUNC_W     = 6;
  localparam int unsigned ALU_FUNC_W = 4;
  localparam int unsigned SEL_W      = 2;

  localparam logic [OPC_W-1:0] OP_BNE   = 4'd0;
  localparam logic [OPC_W-1:0] OP_BEQ   = 4'd1;
  localparam logic [OPC_W-1:0] OP_BGZ   = 4'd2;
  localparam logic [OPC_W-1:0] OP_BLZ   = 4'd3;
  localparam logic [OPC_W-1:0] OP_ADI   = 4'd4;
  localparam logic [OPC_W-1:0] OP_ORI   = 4'd5;
  localparam logic [OPC_W-1:0] OP_LHI   = 4'd6;
  localparam logic [OPC_W-1:0] OP_LWD   = 4'd7;
  localparam logic [OPC_W-1:0] OP_SWD   = 4'd8;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'd9;
  localparam logic [OPC_W-1:0] OP_JAL   = 4'd10;
  localparam logic [OPC_W-1:0] OP_RTYPE = 4'd15;

  localparam logic [FUNC_W-1:0] FN_SHR = 6'd7;
  localparam logic [FUNC_W-1:0] FN_JPR = 6'd25;
  localparam logic [FUNC_W-1:0] FN_JRL = 6'd26;
  localparam logic [FUNC_W-1:0] FN_WWD = 6'd28;
  localparam logic [FUNC_W-1:0] FN_HLT = 6'd29;

  localparam logic [ALU_FUNC_W-1:0] FUNC_ADD = 4'd0;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SUB = 4'd1;
  localparam logic [ALU_FUNC_W-1:0] FUNC_AND = 4'd2;
  localparam logic [ALU_FUNC_W-1:0] FUNC_ORR = 4'd3;
  localparam logic [ALU_FUNC_W-1:0] FUNC_NOT = 4'd4;
  localparam logic [ALU_FUNC_W-1:0] FUNC_TCP = 4'd5;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SHL = 4'd6;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SHR = 4'd7;

  localparam logic [SEL_W-1:0] SRC_A_PC   = 2'd0;
  localparam logic [SEL_W-1:0] SRC_A_RS   = 2'd1;
  localparam logic [SEL_W-1:0] SRC_A_ZERO = 2'd2;
  localparam logic [SEL_W-1:0] SRC_B_RT   = 2'd0;
  localparam logic [SEL_W-1:0] SRC_B_ONE  = 2'd1;
  localparam logic [SEL_W-1:0] SRC_B_SEXT = 2'd2;
  localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'd3;
  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PC_SRC_TARGET = 2'd2;
  localparam logic [SEL_W-1:0] PC_SRC_RS     = 2'd3;
  localparam logic [SEL_W-1:0] REG_DST_RT = 2'd0;
  localparam logic [SEL_W-1:0] REG_DST_RD = 2'd1;
  localparam logic [SEL_W-1:0] REG_DST_R2 = 2'd2;
  localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] M2R_MDR    = 2'd1;
  localparam logic [SEL_W-1:0] M2R_PC     = 2'd2;

  typedef enum logic [2:0] {
    STATE_IF, STATE_ID, STATE_EX, STATE_MEM, STATE_WB, STATE_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_RALU, CLS_ADI, CLS_ORI, CLS_LHI, CLS_LWD, CLS_SWD, CLS_BR,
    CLS_JMP, CLS_JAL, CLS_JPR, CLS_JRL, CLS_WWD, CLS_HLT, CLS_NOP
  } instr_cls_t;

  typedef struct packed {
    logic             pc_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [SEL_W-1:0] reg_dst;
    logic [SEL_W-1:0] mem_to_reg;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] pc_source;
    logic             wwd;
    logic             halt;
    logic             is_done;
  } ctrl_t;

  // Collapse opcode/func into one instruction class; anything unknown is a NOP.
  function automatic instr_cls_t classify(input logic [OPC_W-1:0]  op,
                                          input logic [FUNC_W-1:0] fn);
    instr_cls_t cls;
    cls = CLS_NOP;
    case (op)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls = CLS_BR;
      OP_ADI: cls = CLS_ADI;
      OP_ORI: cls = CLS_ORI;
      OP_LHI: cls = CLS_LHI;
      OP_LWD: cls = CLS_LWD;
      OP_SWD: cls = CLS_SWD;
      OP_JMP: cls = CLS_JMP;
      OP_JAL: cls = CLS_JAL;
      OP_RTYPE: begin
        if (fn <= FN_SHR) cls = CLS_RALU;
        else begin
          case (fn)
            FN_JPR:  cls = CLS_JPR;
            FN_JRL:  cls = CLS_JRL;
            FN_WWD:  cls = CLS_WWD;
            FN_HLT:  cls = CLS_HLT;
            default: cls = CLS_NOP;
          endcase
        end
      end
      default: cls = CLS_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: IR fields and ALU flags in, strobes out.
interface mc_control_unit_if;
  import mc_control_unit_pkg::*;

  logic [OPC_W-1:0]      opcode;
  logic [FUNC_W-1:0]     func_code;
  logic                  alu_zero;
  logic                  alu_sign;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  i_or_d;
  logic                  mem_read;
  logic                  mem_write;
  logic                  ir_write;
  logic                  reg_write;
  logic [SEL_W-1:0]      reg_dst;
  logic [SEL_W-1:0]      mem_to_reg;
  logic [SEL_W-1:0]      alu_src_a;
  logic [SEL_W-1:0]      alu_src_b;
  logic [SEL_W-1:0]      pc_source;
  logic [ALU_FUNC_W-1:0] alu_func_code;
  logic                  wwd;
  logic                  halt;
  logic                  is_done;

  modport master (
    input  opcode, func_code, alu_zero, alu_sign, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_func_code, wwd, halt, is_done
  );

  modport slave (
    output opcode, func_code, alu_zero, alu_sign, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_func_code, wwd, halt, is_done
  );
endinterface

// File: rtl/mc_control_unit_alu_ctrl.sv
// ALU function select: ADD everywhere except EX, where the instruction picks it.
module mc_control_unit_alu_ctrl
  import mc_control_unit_pkg::*;
(
  input  state_t                state,
  input  logic [OPC_W-1:0]      opcode,
  input  logic [FUNC_W-1:0]     func_code,
  output logic [ALU_FUNC_W-1:0] alu_func_code
);
  instr_cls_t cls;

  assign cls = classify(opcode, func_code);

  always_comb begin
    alu_func_code = FUNC_ADD;
    if (state == STATE_EX) begin
      case (cls)
        CLS_RALU: alu_func_code = func_code[ALU_FUNC_W-1:0];
        CLS_ORI:  alu_func_code = FUNC_ORR;
        CLS_BR:   alu_func_code = FUNC_SUB;
        default:  alu_func_code = FUNC_ADD;
      endcase
    end
  end
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 16-bit TSC CPU (IF/ID/EX/MEM/WB/HALT).
// Define MEM_WAIT_EN to stall IF and MEM until mem_ready.
module mc_control_unit
  import mc_control_unit_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  mc_control_unit_if.master bus
);
  state_t                state_q;
  state_t                state_d;
  ctrl_t                 ctrl_c;
  ctrl_t                 ctrl_o;
  instr_cls_t            cls;
  logic [ALU_FUNC_W-1:0] alu_func_c;
  logic                  mem_ok;
  logic                  br_taken;

  assign cls = classify(bus.opcode, bus.func_code);

`ifdef MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok = 1'b1;
`endif

  // Branch outcome uses the flags of the rs-rt subtraction performed in EX.
  always_comb begin
    br_taken = 1'b0;
    case (bus.opcode)
      OP_BNE:  br_taken = ~bus.alu_zero;
      OP_BEQ:  br_taken = bus.alu_zero;
      OP_BGZ:  br_taken = ~bus.alu_zero & ~bus.alu_sign;
      OP_BLZ:  br_taken = bus.alu_sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= STATE_IF;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      STATE_IF: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.ir_write  = mem_ok;
        ctrl_c.pc_write  = mem_ok;
        ctrl_c.alu_src_a = SRC_A_PC;
        ctrl_c.alu_src_b = SRC_B_ONE;
        ctrl_c.pc_source = PC_SRC_ALU;
        if (mem_ok) state_d = STATE_ID;
      end
      STATE_ID: begin
        // PC + sext(imm) goes to ALUOut as the branch target for EX.
        ctrl_c.alu_src_b = SRC_B_SEXT;
        state_d          = STATE_EX;
        case (cls)
          CLS_JMP: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PC_SRC_TARGET;
            ctrl_c.is_done   = 1'b1;
            state_d          = STATE_IF;
          end
          CLS_JAL: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PC_SRC_TARGET;
            state_d          = STATE_WB;
          end
          CLS_JRL: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PC_SRC_RS;
            state_d          = STATE_WB;
          end
          CLS_JPR: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PC_SRC_RS;
            ctrl_c.is_done   = 1'b1;
            state_d          = STATE_IF;
          end
          CLS_WWD: begin
            ctrl_c.wwd     = 1'b1;
            ctrl_c.is_done = 1'b1;
            state_d        = STATE_IF;
          end
          CLS_HLT: state_d = STATE_HALT;
          CLS_NOP: begin
            ctrl_c.is_done = 1'b1;
            state_d        = STATE_IF;
          end
          default: state_d = STATE_EX;
        endcase
      end
      STATE_EX: begin
        ctrl_c.alu_src_a = SRC_A_RS;
        ctrl_c.alu_src_b = SRC_B_SEXT;
        state_d          = STATE_WB;
        case (cls)
          CLS_RALU: ctrl_c.alu_src_b = SRC_B_RT;
          CLS_ORI:  ctrl_c.alu_src_b = SRC_B_IMM;
          CLS_LHI: begin
            ctrl_c.alu_src_a = SRC_A_ZERO;
            ctrl_c.alu_src_b = SRC_B_IMM;
          end
          CLS_LWD, CLS_SWD: state_d = STATE_MEM;
          CLS_BR: begin
            // BGZ/BLZ encode rt=$0, so rs-rt is a compare against zero.
            ctrl_c.alu_src_b = SRC_B_RT;
            ctrl_c.pc_write  = br_taken;
            ctrl_c.pc_source = PC_SRC_ALUOUT;
            ctrl_c.is_done   = 1'b1;
            state_d          = STATE_IF;
          end
          default: ctrl_c.alu_src_b = SRC_B_SEXT;
        endcase
      end
      STATE_MEM: begin
        ctrl_c.i_or_d = 1'b1;
        if (cls == CLS_SWD) begin
          ctrl_c.mem_write = 1'b1;
          ctrl_c.is_done   = mem_ok;
          if (mem_ok) state_d = STATE_IF;
        end else begin
          ctrl_c.mem_read = 1'b1;
          if (mem_ok) state_d = STATE_WB;
        end
      end
      STATE_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.is_done   = 1'b1;
        state_d          = STATE_IF;
        case (cls)
          CLS_RALU: ctrl_c.reg_dst = REG_DST_RD;
          CLS_LWD:  ctrl_c.mem_to_reg = M2R_MDR;
          CLS_JAL, CLS_JRL: begin
            ctrl_c.reg_dst    = REG_DST_R2;
            ctrl_c.mem_to_reg = M2R_PC;
          end
          default: ctrl_c.reg_dst = REG_DST_RT;
        endcase
      end
      STATE_HALT: ctrl_c.halt = 1'b1;
      default:    state_d = STATE_IF;
    endcase
  end

  mc_control_unit_alu_ctrl u_alu_ctrl (
    .state         (state_q),
    .opcode        (bus.opcode),
    .func_code     (bus.func_code),
    .alu_func_code (alu_func_c)
  );

  // Outputs are forced quiet the moment reset_n falls, even mid-instruction.
  assign ctrl_o            = reset_n ? ctrl_c : '0;
  assign bus.alu_func_code = reset_n ? alu_func_c : FUNC_ADD;
  assign bus.pc_write      = ctrl_o.pc_write;
  assign bus.i_or_d        = ctrl_o.i_or_d;
  assign bus.mem_read      = ctrl_o.mem_read;
  assign bus.mem_write     = ctrl_o.mem_write;
  assign bus.ir_write      = ctrl_o.ir_write;
  assign bus.reg_write     = ctrl_o.reg_write;
  assign bus.reg_dst       = ctrl_o.reg_dst;
  assign bus.mem_to_reg    = ctrl_o.mem_to_reg;
  assign bus.alu_src_a     = ctrl_o.alu_src_a;
  assign bus.alu_src_b     = ctrl_o.alu_src_b;
  assign bus.pc_source     = ctrl_o.pc_source;
  assign bus.wwd           = ctrl_o.wwd;
  assign bus.halt          = ctrl_o.halt;
  assign bus.is_done       = ctrl_o.is_done;
endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction cycle model, vector table,
// random instruction stream and reset/halt/wait sequences.
module tb_mc_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_func;
    logic       wwd;
    logic       halt;
    logic       is_done;
  } obs_t;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic       z;
    logic       s;
    int         exp_len;
    logic       exp_last_pcw;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic obs_t sample();
    obs_t o;
    o.pc_write   = bus.pc_write;
    o.i_or_d     = bus.i_or_d;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.ir_write   = bus.ir_write;
    o.reg_write  = bus.reg_write;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.src_a      = bus.alu_src_a;
    o.src_b      = bus.alu_src_b;
    o.pc_source  = bus.pc_source;
    o.alu_func   = bus.alu_func_code;
    o.wwd        = bus.wwd;
    o.halt       = bus.halt;
    o.is_done    = bus.is_done;
    return o;
  endfunction

  // Cycles from IF to the is_done cycle; 0 means the instruction never retires.
  function automatic int instr_len(input logic [3:0] op, input logic [5:0] fn);
    if (op == 4'd15) begin
      if (fn <= 6'd7)  return 4;
      if (fn == 6'd26) return 3;
      if (fn == 6'd29) return 0;
      return 2;
    end
    if (op <= 4'd3) return 3;
    if (op <= 4'd6) return 4;
    if (op == 4'd7) return 5;
    if (op == 4'd8) return 4;
    if (op == 4'd10) return 3;
    return 2;
  endfunction

  function automatic logic taken(input logic [3:0] op, input logic z, input logic s);
    case (op)
      4'd0:    return !z;
      4'd1:    return z;
      4'd2:    return !z && !s;
      default: return s;
    endcase
  endfunction

  // Expected strobes in cycle k (0 = fetch) of one instruction.
  function automatic obs_t model(input logic [3:0] op, input logic [5:0] fn,
                                 input logic z, input logic s, input int k);
    obs_t e;
    bit   ralu, jal, jrl, jmp, jpr, wwd, hlt, br, ldst;
    int   len;
    ralu = (op == 4'd15) && (fn <= 6'd7);
    jal  = (op == 4'd10);
    jrl  = (op == 4'd15) && (fn == 6'd26);
    jmp  = (op == 4'd9);
    jpr  = (op == 4'd15) && (fn == 6'd25);
    wwd  = (op == 4'd15) && (fn == 6'd28);
    hlt  = (op == 4'd15) && (fn == 6'd29);
    br   = (op <= 4'd3);
    ldst = (op == 4'd7) || (op == 4'd8);
    len  = instr_len(op, fn);
    e    = '0;
    if (k == 0) begin
      e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; e.src_b = 2'd1;
      return e;
    end
    if (hlt && k >= 2) begin
      e.halt = 1'b1;
      return e;
    end
    e.is_done = (k == len - 1);
    if (k == 1) begin
      e.src_b = 2'd2;
      if (jmp || jal) begin e.pc_write = 1'b1; e.pc_source = 2'd2; end
      if (jpr || jrl) begin e.pc_write = 1'b1; e.pc_source = 2'd3; end
      e.wwd = wwd;
      return e;
    end
    if (jal || jrl) begin
      e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
      return e;
    end
    if (k == 2) begin
      e.src_a = (op == 4'd6) ? 2'd2 : 2'd1;
      e.src_b = (br || ralu) ? 2'd0 : ((op == 4'd5 || op == 4'd6) ? 2'd3 : 2'd2);
      if (br) begin
        e.alu_func = 4'd1; e.pc_write = taken(op, z, s); e.pc_source = 2'd1;
      end else if (ralu) e.alu_func = fn[3:0];
      else if (op == 4'd5) e.alu_func = 4'd3;
      return e;
    end
    if (ldst && k == 3) begin
      e.i_or_d = 1'b1; e.mem_read = (op == 4'd7); e.mem_write = (op == 4'd8);
      return e;
    end
    e.reg_write  = 1'b1;
    e.reg_dst    = ralu ? 2'd1 : 2'd0;
    e.mem_to_reg = (op == 4'd7) ? 2'd1 : 2'd0;
    return e;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Run one instruction from IF, comparing every cycle with the model.
  task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input logic z,
                           input logic s, input bit rnd, output int len, output obs_t last);
    obs_t act, exp;
    logic zz, ss;
    int   limit;
    len   = 0;
    last  = '0;
    limit = (instr_len(op, fn) == 0) ? 6 : 8;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      zz = rnd ? 1'($urandom_range(0, 1)) : z;
      ss = rnd ? 1'($urandom_range(0, 1)) : s;
      bus.opcode    = op;
      bus.func_code = fn;
      bus.alu_zero  = zz;
      bus.alu_sign  = ss;
`ifndef MEM_WAIT_EN
      if (rnd) bus.mem_ready = 1'($urandom_range(0, 1));
`endif
      #1;
      act  = sample();
      exp  = model(op, fn, zz, ss, k);
      last = act;
      check($sformatf("op%0d/fn%0d cycle%0d", op, fn, k), act, exp);
      if (act.is_done) begin
        len = k + 1;
        break;
      end
    end
`ifndef MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    check_int($sformatf("op%0d/fn%0d length", op, fn), len, instr_len(op, fn));
  endtask

  // Assert reset between edges, expect silence, release just after a rising edge.
  task automatic pulse_reset(input string tag);
    #1 reset_n = 1'b0;
    #1 check({tag, " async reset"}, sample(), '0);
    @(posedge clk);
    #2 check({tag, " reset held"}, sample(), '0);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  vec_t       vecs[19];
  int         len;
  int         pcw_cnt;
  obs_t       last, act, exp;
  logic [3:0] rop;
  logic [5:0] rfn;

  initial begin
    vecs[0]  = '{4'd15, 6'd0,  1'b0, 1'b0, 4, 1'b0};
    vecs[1]  = '{4'd15, 6'd1,  1'b0, 1'b0, 4, 1'b0};
    vecs[2]  = '{4'd15, 6'd7,  1'b0, 1'b0, 4, 1'b0};
    vecs[3]  = '{4'd4,  6'd5,  1'b0, 1'b0, 4, 1'b0};
    vecs[4]  = '{4'd5,  6'd9,  1'b0, 1'b0, 4, 1'b0};
    vecs[5]  = '{4'd6,  6'd1,  1'b0, 1'b0, 4, 1'b0};
    vecs[6]  = '{4'd7,  6'd2,  1'b0, 1'b0, 5, 1'b0};
    vecs[7]  = '{4'd8,  6'd2,  1'b0, 1'b0, 4, 1'b0};
    vecs[8]  = '{4'd1,  6'd0,  1'b1, 1'b0, 3, 1'b1};
    vecs[9]  = '{4'd1,  6'd0,  1'b0, 1'b0, 3, 1'b0};
    vecs[10] = '{4'd0,  6'd0,  1'b0, 1'b1, 3, 1'b1};
    vecs[11] = '{4'd2,  6'd0,  1'b1, 1'b0, 3, 1'b0};
    vecs[12] = '{4'd3,  6'd0,  1'b0, 1'b1, 3, 1'b1};
    vecs[13] = '{4'd9,  6'd3,  1'b0, 1'b0, 2, 1'b1};
    vecs[14] = '{4'd10, 6'd3,  1'b0, 1'b0, 3, 1'b0};
    vecs[15] = '{4'd15, 6'd25, 1'b0, 1'b0, 2, 1'b1};
    vecs[16] = '{4'd15, 6'd26, 1'b0, 1'b0, 3, 1'b0};
    vecs[17] = '{4'd15, 6'd28, 1'b0, 1'b0, 2, 1'b0};
    vecs[18] = '{4'd12, 6'd0,  1'b0, 1'b0, 2, 1'b0};

    reset_n       = 1'b0;
    bus.opcode    = 4'd15;
    bus.func_code = 6'd0;
    bus.alu_zero  = 1'b0;
    bus.alu_sign  = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1 check("reset state", sample(), '0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].s, 1'b0, len, last);
      check_int($sformatf("vec%0d cycles", i), len, vecs[i].exp_len);
      check_int($sformatf("vec%0d final pc_write", i), int'(last.pc_write),
                int'(vecs[i].exp_last_pcw));
    end

    // Undefined R-type func retires as a NOP.
    run_instr(4'd15, 6'd12, 1'b0, 1'b0, 1'b0, len, last);
    check_int("undef func cycles", len, 2);

    // HLT parks in HALT with no retirement; only reset leaves it.
    run_instr(4'd15, 6'd29, 1'b0, 1'b0, 1'b0, len, last);
    check_int("halt held", int'(last.halt), 1);
    pulse_reset("after halt");
    run_instr(4'd4, 6'd0, 1'b0, 1'b0, 1'b0, len, last);

    // Reset in the middle of EX abandons the instruction.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.opcode = 4'd15; bus.func_code = 6'd1;
      #1 check($sformatf("pre-reset cycle%0d", k), sample(), model(4'd15, 6'd1, 1'b0, 1'b0, k));
    end
    pulse_reset("mid EX");
    run_instr(4'd7, 6'd0, 1'b0, 1'b0, 1'b0, len, last);

`ifdef MEM_WAIT_EN
    pcw_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.opcode = 4'd15; bus.func_code = 6'd0; bus.mem_ready = (k == 3);
      #1;
      act = sample();
      exp = model(4'd15, 6'd0, 1'b0, 1'b0, 0);
      if (k < 3) begin exp.pc_write = 1'b0; exp.ir_write = 1'b0; end
      check($sformatf("wait IF cycle%0d", k), act, exp);
      if (act.pc_write) pcw_cnt++;
    end
    check_int("wait pc_write pulses", pcw_cnt, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1 check($sformatf("after wait cycle%0d", k), sample(), model(4'd15, 6'd0, 1'b0, 1'b0, k));
    end
`else
    pcw_cnt = 0;
`endif

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      rfn = 6'($urandom_range(0, 63));
      if (rop == 4'd15) begin
        case ($urandom_range(0, 5))
          0, 1, 2: rfn = 6'($urandom_range(0, 7));
          3:       rfn = 6'd25;
          4:       rfn = 6'd26;
          default: rfn = 6'd28;
        endcase
      end
      run_instr(rop, rfn, 1'b0, 1'b0, 1'b1, len, last);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
